// File: rtl/axi_ram_fill_engine_if.sv
// axi_ram_fill_engine_if: AXI4 write-channel bundle (AW/W/B) between the fill master and the RAM slave.
interface axi_ram_fill_engine_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    modport master (
        output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );
    modport slave (
        input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_ram_fill_engine.sv
// axi_ram_fill_engine: AXI4 burst writer filling RAM with a constant pattern, bursts split at 4 KB.
// Define FILL_INCREMENT_EN to write pattern + global beat index instead of a constant.
module axi_ram_fill_engine #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 17,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int MAX_BURST  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_beats,
    input  logic [DATA_WIDTH-1:0] pattern,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    axi_ram_fill_engine_if.master m_axi
);
    localparam int SZ = $clog2(STRB_WIDTH);
    localparam int W  = CNT_WIDTH > 13 ? CNT_WIDTH : 13;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [DATA_WIDTH-1:0] pat;
    logic [8:0]            beats, beat_cnt;
    logic                  err, done_r, last_burst;
    logic [W-1:0]          to_bnd, cap, blen;
`ifdef FILL_INCREMENT_EN
    logic [DATA_WIDTH-1:0] idx;
`endif
    // Burst length from registered addr/remaining, so awlen stays stable while ADDR waits.
    always_comb begin
        to_bnd = W'((13'h1000 - {1'b0, addr[11:0]}) >> SZ);
        cap    = to_bnd < W'(MAX_BURST) ? to_bnd : W'(MAX_BURST);
        blen   = W'(remaining) < cap ? W'(remaining) : cap;
    end
    assign last_burst = remaining == CNT_WIDTH'(beats) || m_axi.bresp != 2'b00;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && num_beats != '0) state_nx = ADDR;
            ADDR:    if (m_axi.awready) state_nx = DATA;
            DATA:    if (m_axi.wready && beat_cnt == 9'd1) state_nx = RESP;
            RESP:    if (m_axi.bvalid) state_nx = last_burst ? IDLE : ADDR;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            pat       <= '0;
            beats     <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
            done_r    <= 1'b0;
`ifdef FILL_INCREMENT_EN
            idx       <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    err       <= 1'b0;
                    done_r    <= num_beats == '0;
                    addr      <= base_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
                    remaining <= num_beats;
                    pat       <= pattern;
`ifdef FILL_INCREMENT_EN
                    idx       <= '0;
`endif
                end
                ADDR: if (m_axi.awready) begin
                    beats    <= 9'(blen);
                    beat_cnt <= 9'(blen);
                end
                DATA: if (m_axi.wready) begin
                    beat_cnt <= beat_cnt - 9'd1;
`ifdef FILL_INCREMENT_EN
                    idx      <= idx + DATA_WIDTH'(1);
`endif
                end
                RESP: if (m_axi.bvalid) begin
                    addr      <= addr + (ADDR_WIDTH'(beats) << SZ);
                    remaining <= remaining - CNT_WIDTH'(beats);
                    err       <= err | (m_axi.bresp != 2'b00);
                    done_r    <= last_burst;
                end
                default: ;
            endcase
        end
    always_comb begin
        busy          = state != IDLE;
        done          = done_r;
        error         = err;
        m_axi.awvalid = state == ADDR;
        m_axi.awaddr  = addr;
        m_axi.awlen   = state == ADDR ? 8'(blen - W'(1)) : 8'd0;
        m_axi.wvalid  = state == DATA;
        m_axi.wlast   = state == DATA && beat_cnt == 9'd1;
`ifdef FILL_INCREMENT_EN
        m_axi.wdata   = pat + idx;
`else
        m_axi.wdata   = pat;
`endif
        m_axi.bready  = state == RESP;
    end
    assign m_axi.wstrb = '1;
endmodule

// File: tb/tb_axi_ram_fill_engine.sv
// tb_axi_ram_fill_engine: randomized AXI slave with stalls, write log compared against a burst-level fill model.
module tb_axi_ram_fill_engine;
    localparam int AW = 17;
    localparam int DW = 64;
    localparam int SB = 8;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [15:0]   num_beats = '0;
    logic [DW-1:0] pattern = '0;
    logic busy, done, error;
    int checks = 0, errors = 0;
    axi_ram_fill_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SB)) bus ();
    axi_ram_fill_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SB), .MAX_BURST(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_beats(num_beats),
        .pattern(pattern), .busy(busy), .done(done), .error(error), .m_axi(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // observed and expected transaction logs
    logic [AW-1:0] aw_addr_q[$], ea_addr[$], w_addr_q[$], ew_addr[$];
    logic [7:0]    aw_len_q[$], ea_len[$];
    logic [DW-1:0] w_data_q[$], ew_data[$];
    bit stall_en = 0, aw_open = 0, b_fire = 0, aw_hold = 0, w_hold = 0;
    int err_burst = -1, b_pend = 0, b_delay = 0, b_num = 0, beat_in = 0;
    logic [AW-1:0] cur_addr, h_addr;
    logic [7:0]    cur_len, h_len;
    logic [DW-1:0] h_data;
    logic          h_last;
    initial begin
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
                b_pend = 0; b_delay = 0; b_fire = 0; aw_open = 0; beat_in = 0; aw_hold = 0; w_hold = 0;
            end else begin
                if (b_fire) begin bus.bvalid = 0; b_fire = 0; b_num++; end
                bus.awready = !stall_en || $urandom_range(0, 2) == 0;
                bus.wready  = !stall_en || $urandom_range(0, 2) != 0;
                if (!bus.bvalid && b_pend > 0) begin
                    if (b_delay > 0) b_delay--;
                    else begin
                        bus.bvalid = 1;
                        bus.bresp = (b_num == err_burst) ? 2'b10 : 2'b00;
                        b_pend--;
                    end
                end
                #1;
                if (aw_hold) begin
                    check("aw_hold_valid", 64'(bus.awvalid), 64'(1));
                    check("aw_hold_addr", 64'(bus.awaddr), 64'(h_addr));
                    check("aw_hold_len", 64'(bus.awlen), 64'(h_len));
                end
                if (w_hold) begin
                    check("w_hold_valid", 64'(bus.wvalid), 64'(1));
                    check("w_hold_data", 64'(bus.wdata), 64'(h_data));
                    check("w_hold_last", 64'(bus.wlast), 64'(h_last));
                end
                aw_hold = bus.awvalid && !bus.awready; h_addr = bus.awaddr; h_len = bus.awlen;
                w_hold = bus.wvalid && !bus.wready; h_data = bus.wdata; h_last = bus.wlast;
                if (bus.awvalid && bus.awready) begin
                    check("aw_single", 64'({aw_open, b_pend != 0 || bus.bvalid}), 64'(0));
                    aw_addr_q.push_back(bus.awaddr); aw_len_q.push_back(bus.awlen);
                    aw_open = 1; cur_addr = bus.awaddr; cur_len = bus.awlen; beat_in = 0;
                end
                if (bus.wvalid && bus.wready) begin
                    check("w_after_aw", 64'(aw_open), 64'(1));
                    w_addr_q.push_back(cur_addr + AW'(8 * beat_in)); w_data_q.push_back(bus.wdata);
                    check("wlast", 64'(bus.wlast), 64'(beat_in == int'(cur_len)));
                    if (beat_in == int'(cur_len)) begin
                        aw_open = 0; b_pend++;
                        b_delay = stall_en ? int'($urandom_range(0, 5)) : 0;
                    end
                    beat_in++;
                end
                if (bus.bvalid && bus.bready) b_fire = 1;
            end
        end
    end
    // Expected bursts/beats from the fill rules: min(remaining, 16, beats to 4 KB), address wraps mod 2**AW.
    task automatic build_model(input logic [AW-1:0] base, input int n, input logic [DW-1:0] pat, input int errb);
        int a, rem, idx, b, k, tb;
        a = int'(base) & ~7; rem = n; idx = 0; b = 0;
        ea_addr.delete(); ea_len.delete(); ew_addr.delete(); ew_data.delete();
        while (rem > 0) begin
            tb = (4096 - a % 4096) / 8;
            k = rem > 16 ? 16 : rem;
            if (k > tb) k = tb;
            ea_addr.push_back(AW'(a)); ea_len.push_back(8'(k - 1));
            for (int j = 0; j < k; j++) begin
                ew_addr.push_back(AW'((a + 8 * j) % (1 << AW)));
`ifdef FILL_INCREMENT_EN
                ew_data.push_back(pat + DW'(idx));
`else
                ew_data.push_back(pat);
`endif
                idx++;
            end
            a = (a + 8 * k) % (1 << AW); rem -= k;
            if (b == errb) break;
            b++;
        end
    endtask
    task automatic run(input logic [AW-1:0] base, input int n, input logic [DW-1:0] pat, input int errb, input bit stl);
        int cyc;
        bit got, exp_err;
        build_model(base, n, pat, errb);
        exp_err = errb >= 0 && ea_addr.size() == errb + 1;
        aw_addr_q.delete(); aw_len_q.delete(); w_addr_q.delete(); w_data_q.delete();
        @(negedge clk);
        err_burst = errb; stall_en = stl; b_num = 0;
        base_addr = base; num_beats = 16'(n); pattern = pat; start = 1;
        @(negedge clk);
        start = 0;
        got = 0; cyc = 0;
        while (!got && cyc < 4000) begin
            #2;
            if (done) got = 1;
            else begin cyc++; @(negedge clk); end
        end
        check("done_seen", 64'(got), 64'(1));
        if (n == 0) check("zero_latency", 64'(cyc), 64'(0));
        check("busy_at_done", 64'(busy), 64'(0));
        check("error_at_done", 64'(error), 64'(exp_err));
        check("aw_count", 64'(aw_addr_q.size()), 64'(ea_addr.size()));
        for (int i = 0; i < aw_addr_q.size() && i < ea_addr.size(); i++) begin
            check("awaddr", 64'(aw_addr_q[i]), 64'(ea_addr[i]));
            check("awlen", 64'(aw_len_q[i]), 64'(ea_len[i]));
        end
        check("beat_count", 64'(w_addr_q.size()), 64'(ew_addr.size()));
        for (int i = 0; i < w_addr_q.size() && i < ew_addr.size(); i++) begin
            check("beat_addr", 64'(w_addr_q[i]), 64'(ew_addr[i]));
            check("beat_data", 64'(w_data_q[i]), 64'(ew_data[i]));
        end
        @(negedge clk);
        #2;
        check("done_pulse", 64'(done), 64'(0));
        check("error_held", 64'(error), 64'(exp_err));
    endtask
    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    initial begin
        int n, errb;
        logic [AW-1:0] b;
        bit got;
        repeat (3) @(negedge clk);
        #2;
        check("rst_ctrl", 64'({busy, done, error}), 64'(0));
        check("rst_valids", 64'({bus.awvalid, bus.wvalid, bus.wlast, bus.bready}), 64'(0));
        check("rst_awaddr", 64'(bus.awaddr), 64'(0));
        check("rst_awlen", 64'(bus.awlen), 64'(0));
        check("rst_wdata", 64'(bus.wdata), 64'(0));
        check("rst_wstrb", 64'(bus.wstrb), 64'(8'hFF));
        @(negedge clk);
        rst = 0;
        run(17'h00000, 40, 64'h100, -1, 0);
        run(17'h00FF0, 4, 64'hDEAD_BEEF_0123_4567, -1, 0);
        run(17'h00123, 0, 64'h55, -1, 0);
        run(17'h00000, 40, 64'hA5A5_A5A5_A5A5_A5A5, 0, 1);
        run(17'h00000, 40, 64'h0F0F, -1, 1);
        run(17'h1FFF0, 6, 64'h77, -1, 1);
        run(17'h00F80, 40, 64'h1234, 1, 1);
        for (int i = 0; i < 8; i++) begin
            b = AW'($urandom) & 17'h1FFF8;
            n = int'($urandom_range(1, 70));
            errb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            run(b, n, {$urandom, $urandom}, errb, 1);
        end
        // reset in the middle of a data phase
        stall_en = 0; err_burst = -1;
        @(negedge clk);
        base_addr = 17'h00400; num_beats = 16'd40; pattern = 64'h9; start = 1;
        @(negedge clk);
        start = 0;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk);
            #2;
            got = bus.wvalid;
        end
        check("rst_wait_data", 64'(got), 64'(1));
        rst = 1;
        #1;
        check("mid_rst_valids", 64'({bus.awvalid, bus.wvalid, bus.bready}), 64'(0));
        check("mid_rst_busy_done", 64'({busy, done}), 64'(0));
        @(negedge clk);
        #3;
        rst = 0;
        repeat (2) @(negedge clk);
        run(17'h00200, 10, 64'h100, -1, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
